// File: rtl/load_store_unit.sv
// load_store_unit: byte/word load-store engine for a 16-bit sync RAM; req/we/byte_en/sign/addr/wdata in, busy/done/rdata out, mem_addr/mem_we/mem_din/mem_dout RAM side
module load_store_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk50MHz,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic              byte_en,
    input  logic              sign,
    input  logic [ADDR_W:0]   addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, DONE} state_t;
    state_t state, next;
    logic we_r, byte_r, sign_r, lane_r;
    logic [7:0] wb_r, lane;
    assign lane   = lane_r ? mem_dout[15:8] : mem_dout[7:0];
    assign busy   = state == RD_ISSUE || state == RD_WAIT || state == WRITE;
    assign done   = state == DONE;
    assign mem_we = state == WRITE;
    always_ff @(posedge clk50MHz or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next;
    always_comb begin
        next = state == IDLE     ? (req ? ((we && !byte_en) ? WRITE : RD_ISSUE) : IDLE) :
               state == RD_ISSUE ? RD_WAIT :
               state == RD_WAIT  ? (we_r ? WRITE : DONE) :
               state == WRITE    ? DONE : IDLE;
    end
    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            we_r     <= 1'b0;
            byte_r   <= 1'b0;
            sign_r   <= 1'b0;
            lane_r   <= 1'b0;
            wb_r     <= '0;
            rdata    <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (state == IDLE && req) begin
            we_r     <= we;
            byte_r   <= byte_en;
            sign_r   <= sign;
            lane_r   <= addr[0];
            wb_r     <= wdata[7:0];
            mem_addr <= addr[ADDR_W:1];
            mem_din  <= wdata;
        end else if (state == RD_WAIT) begin
            if (we_r) mem_din <= lane_r ? {wb_r, mem_dout[7:0]} : {mem_dout[15:8], wb_r};
            else      rdata   <= byte_r ? {{8{sign_r & lane[7]}}, lane} : mem_dout;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven check of load_store_unit against a behavioural sync RAM
module tb_load_store_unit;
    logic        clk50MHz = 0, reset = 1, req = 0, we = 0, byte_en = 0, sign = 0;
    logic [10:0] addr = 0;
    logic [15:0] wdata = 0, rdata, mem_din, mem_dout;
    logic [9:0]  mem_addr;
    logic        busy, done, mem_we;
    logic [15:0] ram [0:1023];
    int checks = 0, errors = 0;

    load_store_unit dut (
        .clk50MHz(clk50MHz), .reset(reset), .req(req), .we(we), .byte_en(byte_en),
        .sign(sign), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk50MHz = ~clk50MHz;

    always @(posedge clk50MHz) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    typedef struct {
        logic        we, be, sg;
        logic [10:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata, word;
    } vec_t;
    vec_t v [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic b, input logic s, input logic [10:0] a, input logic [15:0] d);
        we = w; byte_en = b; sign = s; addr = a; wdata = d; req = 1;
    endtask

    task automatic run_op(input vec_t t, input int idx);
        int lat, pulses;
        lat = -1; pulses = 0;
        @(negedge clk50MHz);
        drive(t.we, t.be, t.sg, t.addr, t.wdata);
        @(posedge clk50MHz);
        #1 req = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk50MHz);
            chk($sformatf("v%0d_busy_done_overlap", idx), {31'd0, busy & done}, 0);
            pulses += int'(mem_we);
            if (done) begin lat = n; break; end
            @(posedge clk50MHz);
        end
        chk($sformatf("v%0d_latency", idx), lat, t.lat);
        chk($sformatf("v%0d_we_pulses", idx), pulses, {31'd0, t.we});
        chk($sformatf("v%0d_rdata", idx), {16'd0, rdata}, {16'd0, t.rdata});
        chk($sformatf("v%0d_mem_addr", idx), {22'd0, mem_addr}, {22'd0, t.addr[10:1]});
        chk($sformatf("v%0d_ram_word", idx), {16'd0, ram[t.addr[10:1]]}, {16'd0, t.word});
    endtask

    initial begin
        logic b_seen [6];
        logic d_seen [6];
        int   k;
        for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
        ram[5] = 16'h80F3;
        ram[3] = 16'h1234;
        //        we    be    sg    addr      wdata     lat rdata     word
        v[0] = '{1'b1, 1'b0, 1'b0, 11'h004, 16'hBEEF, 1, 16'h0000, 16'hBEEF};
        v[1] = '{1'b0, 1'b0, 1'b0, 11'h004, 16'h0000, 2, 16'hBEEF, 16'hBEEF};
        v[2] = '{1'b0, 1'b1, 1'b1, 11'h00A, 16'h0000, 2, 16'hFFF3, 16'h80F3};
        v[3] = '{1'b0, 1'b1, 1'b1, 11'h00B, 16'h0000, 2, 16'hFF80, 16'h80F3};
        v[4] = '{1'b0, 1'b1, 1'b0, 11'h00B, 16'h0000, 2, 16'h0080, 16'h80F3};
        v[5] = '{1'b1, 1'b1, 1'b0, 11'h007, 16'h99AB, 3, 16'h0080, 16'hAB34};
        v[6] = '{1'b1, 1'b1, 1'b0, 11'h006, 16'h77CD, 3, 16'h0080, 16'hABCD};
        v[7] = '{1'b0, 1'b0, 1'b0, 11'h007, 16'h0000, 2, 16'hABCD, 16'hABCD};
        v[8] = '{1'b0, 1'b1, 1'b1, 11'h006, 16'h0000, 2, 16'hFFCD, 16'hABCD};

        #3;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_mem_we", {31'd0, mem_we}, 0);
        chk("reset_rdata", {16'd0, rdata}, 0);
        chk("reset_mem_addr", {22'd0, mem_addr}, 0);
        chk("reset_mem_din", {16'd0, mem_din}, 0);
        @(negedge clk50MHz);
        reset = 0;
        @(negedge clk50MHz);
        chk("post_reset_busy", {31'd0, busy}, 0);

        for (int i = 0; i < 9; i++) run_op(v[i], i);

        // req held high across a byte store: second accept only after the IDLE cycle following DONE
        @(negedge clk50MHz);
        drive(1'b1, 1'b1, 1'b0, 11'h004, 16'h0011);
        @(posedge clk50MHz);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk50MHz);
            b_seen[n] = busy;
            d_seen[n] = done;
            chk($sformatf("hs_overlap_%0d", n), {31'd0, busy & done}, 0);
            if (n == 3) chk("hs_ram_word", {16'd0, ram[2]}, 32'hBE11);
            if (n < 5) @(posedge clk50MHz);
        end
        req = 0;
        chk("hs_busy_seq", {26'd0, b_seen[0], b_seen[1], b_seen[2], b_seen[3], b_seen[4], b_seen[5]}, 32'b111001);
        chk("hs_done_seq", {26'd0, d_seen[0], d_seen[1], d_seen[2], d_seen[3], d_seen[4], d_seen[5]}, 32'b000100);
        k = 0;
        while (!done && k < 10) begin @(negedge clk50MHz); k++; end
        chk("hs_second_done", {31'd0, done}, 1);
        chk("hs_second_latency", k, 3);

        // reset asserted while the byte-store write is pending
        @(negedge clk50MHz);
        drive(1'b1, 1'b1, 1'b0, 11'h00A, 16'h0055);
        @(posedge clk50MHz);
        #1 req = 0;
        @(posedge clk50MHz);
        @(posedge clk50MHz);
        @(negedge clk50MHz);
        chk("abort_mem_we_before", {31'd0, mem_we}, 1);
        chk("abort_mem_din_merge", {16'd0, mem_din}, 32'h8055);
        #1 reset = 1;
        #1;
        chk("abort_mem_we", {31'd0, mem_we}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_rdata", {16'd0, rdata}, 0);
        chk("abort_mem_addr", {22'd0, mem_addr}, 0);
        chk("abort_mem_din", {16'd0, mem_din}, 0);
        @(posedge clk50MHz);
        @(negedge clk50MHz);
        chk("abort_ram_word", {16'd0, ram[5]}, 32'h80F3);
        reset = 0;
        k = 0;
        repeat (4) begin @(negedge clk50MHz); k += int'(done); end
        chk("abort_no_done", k, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential memory-access engine between the datapath and a 16-bit-word synchronous block RAM.
- Runs byte and word loads and stores from the CPU side over a req/done handshake.
- Byte loads are zero- or sign-extended to 16 bits; the datapath does not extend them.
- Byte stores use a read-modify-write so the other byte in the word is preserved.

Parameters:
- DATA_W, 16, data width; must be 16 (two bytes per word).
- ADDR_W, 10, RAM word-address width; the CPU byte address is ADDR_W+1 bits.

Ports:
- clk50MHz  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- byte_en  input  1  1 = byte access, 0 = word access.
- sign  input  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  ADDR_W+1  byte address; bit 0 selects the byte, [ADDR_W:1] is the word address.
- wdata  input  16  store data; byte stores use wdata[7:0].
- busy  output  1  high from the accept edge until the edge that raises done.
- done  output  1  one-cycle completion pulse.
- rdata  output  16  load result; valid while done=1 for a load, then held until the next load completes.
- mem_addr  output  ADDR_W  RAM word address, registered.
- mem_we  output  1  RAM write enable, registered.
- mem_din  output  16  RAM write data, registered.
- mem_dout  input  16  RAM read data; 1-cycle synchronous read latency (registered on the edge that samples mem_addr).

Behaviour:
- Reset, asynchronous and active-high: state=IDLE; busy, done, mem_we = 0; rdata, mem_addr, mem_din = 0. Asserting reset mid-operation aborts the access immediately: mem_we drops without waiting for a clock and no done is produced.
- Accept: at edge E0, in IDLE with req=1, the unit latches we, byte_en, sign, addr and wdata, sets busy=1, and drives mem_addr=addr[ADDR_W:1].
- req is ignored while busy=1, and ignored in the DONE cycle.
- Byte lane: little-endian; addr[0]=0 is bits [7:0], addr[0]=1 is bits [15:8].
- Word accesses ignore addr[0] (aligned down).
- States: IDLE, RD_ISSUE, RD_WAIT, WRITE, DONE.
- Word store: at E0 go to WRITE with mem_we=1 and mem_din=wdata. At E1 the RAM writes; go to DONE with done=1, busy=0, mem_we=0. Latency is 1 edge.
- Load: E0 → RD_ISSUE. E1: RAM samples mem_addr → RD_WAIT. E2: capture mem_dout into rdata, go to DONE with done=1, busy=0. Latency is 2 edges.
  - Word load: rdata = mem_dout.
  - Byte load: rdata = {8{sign & lane[7]}, lane}.
- Byte store: E0 → RD_ISSUE. E1 → RD_WAIT. At E2, merge wdata[7:0] into the selected lane of mem_dout, leave the other lane unchanged, set mem_din to the merge result and mem_we=1 → WRITE. E3: write lands; go to DONE with done=1, busy=0, mem_we=0. Latency is 3 edges.
- DONE lasts exactly one cycle, then IDLE. A new req is accepted at the earliest on the edge after DONE.
- mem_we is high for exactly one cycle per store and is never high during loads.
- mem_addr holds its last value in IDLE.
- rdata is unchanged by stores.

Test Plan:
- Reset: hold reset high mid-clock → all outputs 0 with no clock edge; release → IDLE, busy=0.
- Word store then word load, addr=0x004: store wdata=0xBEEF → mem_we pulses one cycle at word address 2, done 1 edge after accept. Load → rdata=0xBEEF, done 2 edges after accept.
- Byte loads from a word holding 0x80F3 at word address 5:
  - addr=0x00A, sign=1 → rdata=0xFFF3.
  - addr=0x00B, sign=1 → rdata=0xFF80.
  - addr=0x00B, sign=0 → rdata=0x0080.
- Byte store RMW: word address 3 holds 0x1234; store byte 0xAB to addr=0x007 → RAM word becomes 0xAB34, done 3 edges after accept, exactly one mem_we pulse. Repeat at addr=0x006 with 0xCD → 0xABCD.
- Handshake: pulse req every cycle during a byte store → only the first request is accepted, the next is accepted the cycle after DONE, and busy/done never overlap.
- Abort: assert reset during the WRITE state of a byte store → mem_we falls asynchronously, no done, RAM word unchanged.
